vga_scan_out: RTL

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_scan_out.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// VGA raster timing generator with registered colour/sync output stage.
// Define VGA_CLKDIV_EN to derive pix_tick as clk/2; otherwise every clk is a pixel.
module vga_scan_out #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       tick_q;
  logic       fs_q;
  logic       hs_q, vs_q, blank_n_q;
  logic [7:0] r_q, g_q, b_q;

`ifdef VGA_CLKDIV_EN
  logic       phase_q;
`endif

  logic h_last, v_last;
  logic raw_vis, raw_hs, raw_vs;

  assign h_last  = (h_q == H_LAST);
  assign v_last  = (v_q == V_LAST);
  assign raw_vis = (h_q < H_VIS) && (v_q < V_VIS);
  assign raw_hs  = !((h_q >= HS_LO) && (h_q <= HS_HI));
  assign raw_vs  = !((v_q >= VS_LO) && (v_q <= VS_HI));

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef VGA_CLKDIV_EN
      phase_q   <= 1'b0;
`endif
      tick_q    <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      fs_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
`ifdef VGA_CLKDIV_EN
      phase_q <= ~phase_q;
      tick_q  <= phase_q;
`else
      tick_q  <= 1'b1;
`endif
      fs_q <= tick_q && h_last && v_last;
      // Sync, blank and colour share one register so they stay aligned
      if (tick_q) begin
        h_q       <= h_d;
        v_q       <= v_d;
        hs_q      <= raw_hs;
        vs_q      <= raw_vs;
        blank_n_q <= raw_vis;
        r_q       <= raw_vis ? R : 8'd0;
        g_q       <= raw_vis ? G : 8'd0;
        b_q       <= raw_vis ? B : 8'd0;
      end
    end
  end

  assign h_counter   = h_q;
  assign v_counter   = v_q;
  assign pix_tick    = tick_q;
  assign frame_start = fs_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule
